// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use interlock, multi-cycle MDU stall
// sequencing, deferred IF/ID flush and a saturating stall-cycle counter.
module pipeline_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_reg_read_en_1,
    input  logic [4:0]  id_reg_addr_1,
    input  logic        id_reg_read_en_2,
    input  logic [4:0]  id_reg_addr_2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_write_reg_addr,
    input  logic        mdu_start,
    input  logic [5:0]  mdu_latency,
    input  logic        flush_req,
    output logic [5:0]  stall,
    output logic        bubble_id_ex,
    output logic        flush_if_id,
    output logic        busy,
    output logic [31:0] stall_cycles
);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } state_t;

    // Hold patterns: {wb,mem,ex,id,if,pc}
    localparam logic [5:0] STALL_MDU = 6'b001111;
    localparam logic [5:0] STALL_LU  = 6'b000111;

    state_t      state;
    logic [5:0]  cnt;
    logic        pend_flush;
    logic        load_use;
    logic        mdu_go;

    // Consumer in ID reads the register a load in EX has not produced yet
    assign load_use = ex_mem_read && (ex_write_reg_addr != 5'd0) &&
                      ((id_reg_read_en_1 && (id_reg_addr_1 == ex_write_reg_addr)) ||
                       (id_reg_read_en_2 && (id_reg_addr_2 == ex_write_reg_addr)));

    // Only ops needing at least two EX cycles start a stall sequence
    assign mdu_go = (state == RUN) && mdu_start && (mdu_latency >= 6'd2);

    // Combinational hazard outputs; the MDU start outranks a load-use hazard
    always_comb begin
        stall        = '0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (mdu_go) begin
                        stall = STALL_MDU;
                    end else if (load_use) begin
                        stall        = STALL_LU;
                        bubble_id_ex = 1'b1;
                    end
                end
                MDU_BUSY: begin
                    if (cnt != '0) begin
                        stall = STALL_MDU;
                    end
                end
                default: begin
                    stall = '0;
                end
            endcase
            flush_if_id = (stall == '0) && (flush_req || pend_flush);
        end
    end

    // MDU sequencer: cnt counts the remaining stalled cycles after the first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mdu_go) begin
                        cnt   <= mdu_latency - 6'd2;
                        state <= MDU_BUSY;
                        busy  <= 1'b1;
                    end
                end
                MDU_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 6'd1;
                    end else begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= RUN;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Flush requests seen while stalled collapse into one pending flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_flush <= 1'b0;
        end else if (stall != '0) begin
            if (flush_req) begin
                pend_flush <= 1'b1;
            end
        end else begin
            pend_flush <= 1'b0;
        end
    end

    // Saturating count of cycles in which the PC is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall[0] && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: occupancy-based reference model
// compared every negedge, plus directed literal checks.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic        id_reg_read_en_1;
    logic [4:0]  id_reg_addr_1;
    logic        id_reg_read_en_2;
    logic [4:0]  id_reg_addr_2;
    logic        ex_mem_read;
    logic [4:0]  ex_write_reg_addr;
    logic        mdu_start;
    logic [5:0]  mdu_latency;
    logic        flush_req;
    logic [5:0]  stall;
    logic        bubble_id_ex;
    logic        flush_if_id;
    logic        busy;
    logic [31:0] stall_cycles;

    int n_assert = 0;
    int n_fail   = 0;

    pipeline_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .id_reg_read_en_1  (id_reg_read_en_1),
        .id_reg_addr_1     (id_reg_addr_1),
        .id_reg_read_en_2  (id_reg_read_en_2),
        .id_reg_addr_2     (id_reg_addr_2),
        .ex_mem_read       (ex_mem_read),
        .ex_write_reg_addr (ex_write_reg_addr),
        .mdu_start         (mdu_start),
        .mdu_latency       (mdu_latency),
        .flush_req         (flush_req),
        .stall             (stall),
        .bubble_id_ex      (bubble_id_ex),
        .flush_if_id       (flush_if_id),
        .busy              (busy),
        .stall_cycles      (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_occ = EX cycles the MDU op still occupies after now
    int          m_occ   = 0;
    logic        m_pend  = 1'b0;
    logic [31:0] m_count = '0;
    int          preload_seq = 0;
    int          seen_seq    = 0;

    always @(negedge clk) begin
        logic       lu;
        logic [5:0] e_stall;
        logic       e_bub;
        logic       e_flush;
        if (preload_seq != seen_seq) begin
            seen_seq = preload_seq;
            m_count  = 32'hFFFF_FFFE;
        end
        if (rst) begin
            m_occ = 0; m_pend = 1'b0; m_count = '0;
            check("rst_stall", {26'd0, stall}, 32'd0);
            check("rst_bubble", {31'd0, bubble_id_ex}, 32'd0);
            check("rst_flush", {31'd0, flush_if_id}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_count", stall_cycles, 32'd0);
        end else begin
            check("m_busy", {31'd0, busy}, {31'd0, (m_occ > 0)});
            check("m_count", stall_cycles, m_count);
            lu = ex_mem_read && (ex_write_reg_addr != 0) &&
                 ((id_reg_read_en_1 && id_reg_addr_1 == ex_write_reg_addr) ||
                  (id_reg_read_en_2 && id_reg_addr_2 == ex_write_reg_addr));
            e_stall = 6'd0;
            e_bub   = 1'b0;
            if (m_occ == 0) begin
                if (mdu_start && mdu_latency >= 2) begin
                    e_stall = 6'b001111;
                    m_occ   = int'(mdu_latency) - 1;
                end else if (lu) begin
                    e_stall = 6'b000111;
                    e_bub   = 1'b1;
                end
            end else begin
                e_stall = (m_occ > 1) ? 6'b001111 : 6'b000000;
                m_occ   = m_occ - 1;
            end
            e_flush = (e_stall == 0) && (flush_req || m_pend);
            check("m_stall", {26'd0, stall}, {26'd0, e_stall});
            check("m_bubble", {31'd0, bubble_id_ex}, {31'd0, e_bub});
            check("m_flush", {31'd0, flush_if_id}, {31'd0, e_flush});
            m_pend = (e_stall != 0) ? (m_pend || flush_req) : 1'b0;
            if (e_stall[0] && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_reg_read_en_1 = 0; id_reg_addr_1 = 0;
        id_reg_read_en_2 = 0; id_reg_addr_2 = 0;
        ex_mem_read = 0; ex_write_reg_addr = 0;
        mdu_start = 0; mdu_latency = 0; flush_req = 0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        ex_mem_read = 1; ex_write_reg_addr = rd;
        id_reg_read_en_1 = 1; id_reg_addr_1 = rd;
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        repeat (2) @(posedge clk);
        #1;
        check("d_reset_stall", {26'd0, stall}, 32'd0);
        check("d_reset_count", stall_cycles, 32'd0);
        rst = 1'b0;
        cyc();

        // Load-use on port 1
        set_lu(5'd5);
        #1;
        check("d_lu_stall", {26'd0, stall}, 32'h07);
        check("d_lu_bubble", {31'd0, bubble_id_ex}, 32'd1);
        cyc();
        clear_in();
        #1;
        check("d_lu_nostall", {26'd0, stall}, 32'd0);
        check("d_lu_count", stall_cycles, 32'd1);
        // Destination x0 never interlocks
        set_lu(5'd0);
        #1;
        check("d_x0_stall", {26'd0, stall}, 32'd0);
        cyc();
        // Load-use on port 2
        clear_in();
        ex_mem_read = 1; ex_write_reg_addr = 5'd7;
        id_reg_read_en_2 = 1; id_reg_addr_2 = 5'd7;
        #1;
        check("d_lu2_bubble", {31'd0, bubble_id_ex}, 32'd1);
        cyc();
        // Matching addresses with read enables off
        id_reg_read_en_2 = 0; id_reg_addr_1 = 5'd7;
        #1;
        check("d_noen_stall", {26'd0, stall}, 32'd0);
        cyc();
        clear_in();

        // MDU latency 4; restart and load-use while busy are ignored
        mdu_start = 1; mdu_latency = 6'd4;
        #1;
        check("d_mdu_stall", {26'd0, stall}, 32'h0F);
        cyc();
        mdu_latency = 6'd9;
        set_lu(5'd5);
        #1;
        check("d_mdu_busy", {31'd0, busy}, 32'd1);
        check("d_mdu_nobub", {31'd0, bubble_id_ex}, 32'd0);
        cyc();
        clear_in();
        cyc();
        #1;
        check("d_mdu_last_busy", {31'd0, busy}, 32'd1);
        check("d_mdu_last_stall", {26'd0, stall}, 32'd0);
        cyc();
        #1;
        check("d_mdu_done", {31'd0, busy}, 32'd0);
        check("d_mdu_count", stall_cycles, 32'd5);

        // Single-cycle ops never stall
        mdu_start = 1; mdu_latency = 6'd1;
        #1;
        check("d_lat1", {26'd0, stall}, 32'd0);
        cyc();
        mdu_latency = 6'd0;
        #1;
        check("d_lat0", {26'd0, stall}, 32'd0);
        cyc();
        clear_in();

        // Flush requested during the second cycle of a latency-4 op
        mdu_start = 1; mdu_latency = 6'd4;
        cyc();
        clear_in();
        flush_req = 1;
        #1;
        check("d_def_hold", {31'd0, flush_if_id}, 32'd0);
        cyc();
        flush_req = 0;
        cyc();
        #1;
        check("d_def_flush", {31'd0, flush_if_id}, 32'd1);
        cyc();
        #1;
        check("d_def_once", {31'd0, flush_if_id}, 32'd0);
        check("d_def_count", stall_cycles, 32'd8);

        // MDU start, load-use and flush in one cycle
        mdu_start = 1; mdu_latency = 6'd3; flush_req = 1;
        set_lu(5'd9);
        #1;
        check("d_sim_stall", {26'd0, stall}, 32'h0F);
        check("d_sim_bubble", {31'd0, bubble_id_ex}, 32'd0);
        check("d_sim_flush0", {31'd0, flush_if_id}, 32'd0);
        cyc();
        clear_in();
        cyc();
        #1;
        check("d_sim_flush", {31'd0, flush_if_id}, 32'd1);
        cyc();
        #1;
        check("d_sim_count", stall_cycles, 32'd10);

        // Reset in the middle of a latency-12 op with a pending flush
        mdu_start = 1; mdu_latency = 6'd12; flush_req = 1;
        cyc();
        clear_in();
        #1;
        check("d_rm_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("d_rm_stall", {26'd0, stall}, 32'd0);
        check("d_rm_busy0", {31'd0, busy}, 32'd0);
        check("d_rm_count", stall_cycles, 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        #1;
        check("d_rm_after_stall", {26'd0, stall}, 32'd0);
        check("d_rm_after_flush", {31'd0, flush_if_id}, 32'd0);
        check("d_rm_after_busy", {31'd0, busy}, 32'd0);

        // Saturation of the stall counter
        cyc();
        force dut.stall_cycles = 32'hFFFF_FFFE;
        preload_seq++;
        #1;
        release dut.stall_cycles;
        #1;
        check("d_sat_preload", stall_cycles, 32'hFFFF_FFFE);
        cyc();
        mdu_start = 1; mdu_latency = 6'd4;
        cyc();
        clear_in();
        cyc();
        cyc();
        cyc();
        #1;
        check("d_sat_hold", stall_cycles, 32'hFFFF_FFFF);
        check("d_sat_busy", {31'd0, busy}, 32'd0);

        repeat (2) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; `clk` is the clock and `rst` is the reset.
REQ-002 SHALL have these ports (all widths in bits):
- clk  in  1  pipeline clock
- rst  in  1  async active-high reset
- id_reg_read_en_1  in  1  ID read port 1 enable
- id_reg_addr_1  in  5  ID read port 1 address
- id_reg_read_en_2  in  1  ID read port 2 enable
- id_reg_addr_2  in  5  ID read port 2 address
- ex_mem_read  in  1  EX instruction is a load
- ex_write_reg_addr  in  5  EX destination register
- mdu_start  in  1  EX begins a multi-cycle op
- mdu_latency  in  6  total EX cycles of that op
- flush_req  in  1  branch/jump redirect from ID
- stall  out  6  {wb,mem,ex,id,if,pc} hold bits
- bubble_id_ex  out  1  load NOP into ID/EX register
- flush_if_id  out  1  clear IF/ID register
- busy  out  1  MDU sequence in progress
- stall_cycles  out  32  count of cycles with stall[0]=1

Function
REQ-003 SHALL implement states RUN and MDU_BUSY, plus a 6-bit down-counter cnt and a 1-bit pend_flush register.
REQ-004 SHALL define load_use = ex_mem_read && ex_write_reg_addr!=0 && ((id_reg_read_en_1 && id_reg_addr_1==ex_write_reg_addr) || (id_reg_read_en_2 && id_reg_addr_2==ex_write_reg_addr)); load_use SHALL be combinational.
REQ-005 In RUN, when mdu_start=1 and mdu_latency>=2, SHALL drive stall=6'b001111 in that cycle, load cnt<=mdu_latency-2, and enter MDU_BUSY.
REQ-006 In RUN, mdu_start with mdu_latency of 0 or 1 SHALL be ignored (single-cycle op, no stall).
REQ-007 In RUN, when mdu_start=1 and load_use=1 in the same cycle, mdu_start SHALL take priority and load_use SHALL be ignored.
REQ-008 In RUN, when load_use=1 and REQ-005 does not apply, SHALL drive stall=6'b000111 and bubble_id_ex=1 combinationally in that cycle.
REQ-009 In MDU_BUSY, when cnt!=0, SHALL drive stall=6'b001111 and decrement cnt.
REQ-010 In MDU_BUSY, when cnt==0, SHALL drive stall=0 and return to RUN; total EX occupancy SHALL equal mdu_latency cycles.
REQ-011 In MDU_BUSY, mdu_start and load_use SHALL be ignored.
REQ-012 busy SHALL equal (state==MDU_BUSY), registered.
REQ-013 In any cycle with stall=0, if flush_req || pend_flush, SHALL drive flush_if_id=1 and clear pend_flush.
REQ-014 In any cycle with stall!=0, if flush_req=1, SHALL set pend_flush and keep flush_if_id=0; repeated requests SHALL collapse into one pending flush.
REQ-015 In every cycle with stall[0]=1, stall_cycles SHALL increment by 1, saturating at 32'hFFFFFFFF.
REQ-016 In all other cases, stall=0, bubble_id_ex=0, and flush_if_id=0.

Reset
REQ-017 When rst=1, SHALL force state=RUN, cnt=0, pend_flush=0, busy=0, and stall_cycles=0 immediately, independent of clk.
REQ-018 When rst=1, SHALL drive stall=0, bubble_id_ex=0, and flush_if_id=0 combinationally.
REQ-019 Assertion of rst during MDU_BUSY SHALL abort the sequence; the first cycle after release SHALL be RUN, with no stall and no pending flush.

Verification
REQ-020 Load-use: ex_mem_read=1, ex_write_reg_addr=5, id_reg_read_en_1=1, id_reg_addr_1=5 -> stall=6'b000111 and bubble_id_ex=1 for exactly that cycle; stall_cycles increments by 1. With ex_write_reg_addr=0 -> no stall.
REQ-021 MDU sequence: mdu_start=1 with mdu_latency=4 -> stall=6'b001111 for 3 consecutive cycles, then 0; busy=1 for 3 cycles; stall_cycles increments by 3. With mdu_latency=1 -> no stall.
REQ-022 Deferred flush: flush_req=1 during cycle 2 of a latency-4 MDU op -> flush_if_id=0 while stalled, then flush_if_id=1 for exactly one cycle, in the first cycle with stall=0.
REQ-023 Simultaneous events: mdu_start=1 (latency 3), load_use=1, and flush_req=1 in the same cycle -> stall=6'b001111, bubble_id_ex=0, pend_flush set; flush_if_id=1 is issued two cycles later.
REQ-024 Reset mid-op: assert rst during MDU_BUSY with cnt=10 -> all outputs 0 immediately; after release, the op is not resumed.
REQ-025 Counter saturation: preload stall_cycles near 32'hFFFFFFFF (force), then apply 3 stalled cycles -> value holds at 32'hFFFFFFFF without wrapping.
